mem_arbiter: RTL and testbench

//  Shares the single cache-side port of the UART memory controller between two requesters:

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 55 +++++
 rtl/mem_arbiter_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the two-port memory arbiter
// (fetch port 0, load/store port 1) in front of the UART memory controller.
package mem_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned RW_LEN_L   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_LSU   = 1'b1
  } port_id_e;

  typedef struct packed {
    logic     valid;
    port_id_e port;
    logic     wr;
  } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and controller-side signals of the memory arbiter.
// The master modport is the arbiter's view; slave is the pipeline/controller view.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DW = DATA_W_DEF,
  parameter int unsigned AW = ADDR_W_DEF
);
  logic                p0_re;
  logic [AW-1:0]       p0_raddr;
  logic [RW_LEN_L-1:0] p0_rlen;
  logic                p0_rack;
  logic [DW-1:0]       p0_dout;

  logic                p1_re;
  logic                p1_we;
  logic [AW-1:0]       p1_raddr;
  logic [AW-1:0]       p1_waddr;
  logic [DW-1:0]       p1_din;
  logic [RW_LEN_L-1:0] p1_rlen;
  logic [RW_LEN_L-1:0] p1_wlen;
  logic                p1_rack;
  logic                p1_wack;
  logic [DW-1:0]       p1_dout;

  logic                c_re;
  logic                c_we;
  logic [AW-1:0]       c_raddr;
  logic [AW-1:0]       c_waddr;
  logic [DW-1:0]       c_din;
  logic [RW_LEN_L-1:0] c_rlen;
  logic [RW_LEN_L-1:0] c_wlen;
  logic [DW-1:0]       c_dout;
  logic                c_rack;
  logic                c_wack;

  modport master (
    input  p0_re, p0_raddr, p0_rlen,
    output p0_rack, p0_dout,
    input  p1_re, p1_we, p1_raddr, p1_waddr, p1_din, p1_rlen, p1_wlen,
    output p1_rack, p1_wack, p1_dout,
    output c_re, c_we, c_raddr, c_waddr, c_din, c_rlen, c_wlen,
    input  c_dout, c_rack, c_wack
  );

  modport slave (
    output p0_re, p0_raddr, p0_rlen,
    input  p0_rack, p0_dout,
    output p1_re, p1_we, p1_raddr, p1_waddr, p1_din, p1_rlen, p1_wlen,
    input  p1_rack, p1_wack, p1_dout,
    input  c_re, c_we, c_raddr, c_waddr, c_din, c_rlen, c_wlen,
    output c_dout, c_rack, c_wack
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Round-robin grant picker: on a tie the port not served last wins;
// the LSU port issues its store before a simultaneously pending load.
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
(
  input  logic     p0_re,
  input  logic     p1_re,
  input  logic     p1_we,
  input  port_id_e last_gnt,
  output grant_t   gnt
);

  logic     p1_req_s;
  port_id_e other_s;

  assign p1_req_s = p1_re | p1_we;
  assign other_s  = (last_gnt == PORT_FETCH) ? PORT_LSU : PORT_FETCH;

  // Pick the winning port and the kind of access it gets
  always_comb begin
    gnt = '{valid: 1'b0, port: PORT_FETCH, wr: 1'b0};
    if (p0_re && p1_req_s) begin
      gnt.valid = 1'b1;
      gnt.port  = other_s;
    end else if (p0_re) begin
      gnt.valid = 1'b1;
      gnt.port  = PORT_FETCH;
    end else if (p1_req_s) begin
      gnt.valid = 1'b1;
      gnt.port  = PORT_LSU;
    end else begin
      gnt.valid = 1'b0;
    end
    gnt.wr = (gnt.port == PORT_LSU) && p1_we;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the UART memory controller: one transaction in
// flight, registered strobes and ack pulses, watchdog-bounded wait, sticky err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned C_DATA_L = DATA_W_DEF,
  parameter int unsigned MADDR_L  = ADDR_W_DEF,
  parameter int unsigned TO_CYC   = 4096
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus,
  output logic          err
);

  localparam int unsigned     WD_W   = $clog2(TO_CYC);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TO_CYC - 1);

  arb_state_e          state_r, state_nxt_s;
  port_id_e            last_gnt_r, last_gnt_nxt_s;
  logic                cur_wr_r, cur_wr_nxt_s;
  logic [WD_W-1:0]     wd_r, wd_nxt_s;
  logic                c_re_r, c_re_nxt_s, c_we_r, c_we_nxt_s;
  logic [MADDR_L-1:0]  c_raddr_r, c_raddr_nxt_s, c_waddr_r, c_waddr_nxt_s;
  logic [C_DATA_L-1:0] c_din_r, c_din_nxt_s;
  logic [RW_LEN_L-1:0] c_rlen_r, c_rlen_nxt_s, c_wlen_r, c_wlen_nxt_s;
  logic                p0_rack_r, p0_rack_nxt_s, p1_rack_r, p1_rack_nxt_s;
  logic                p1_wack_r, p1_wack_nxt_s, err_r, err_nxt_s;
  logic [C_DATA_L-1:0] p0_dout_r, p0_dout_nxt_s, p1_dout_r, p1_dout_nxt_s;

  grant_t              gnt_s;
  logic                ack_hit_s, timeout_s, done_s;
  logic [C_DATA_L-1:0] rdata_s;

  mem_arbiter_pick u_pick (
    .p0_re    (bus.p0_re),
    .p1_re    (bus.p1_re),
    .p1_we    (bus.p1_we),
    .last_gnt (last_gnt_r),
    .gnt      (gnt_s)
  );

  // Only the ack matching the issued kind counts; anything else is left to the watchdog
  assign ack_hit_s = cur_wr_r ? bus.c_wack : bus.c_rack;
  assign timeout_s = !ack_hit_s && (wd_r == WD_MAX);
  assign done_s    = ack_hit_s || timeout_s;
  assign rdata_s   = timeout_s ? {C_DATA_L{1'b0}} : bus.c_dout;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:    if (gnt_s.valid) state_nxt_s = ST_WAIT;    else state_nxt_s = ST_IDLE;
      ST_WAIT:    if (done_s)      state_nxt_s = ST_RELEASE; else state_nxt_s = ST_WAIT;
      ST_RELEASE: if (!bus.c_rack && !bus.c_wack) state_nxt_s = ST_IDLE;
                  else state_nxt_s = ST_RELEASE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of every registered output and transaction bookkeeping
  always_comb begin
    last_gnt_nxt_s = last_gnt_r;
    cur_wr_nxt_s   = cur_wr_r;
    wd_nxt_s       = wd_r;
    c_re_nxt_s     = c_re_r;
    c_we_nxt_s     = c_we_r;
    c_raddr_nxt_s  = c_raddr_r;
    c_waddr_nxt_s  = c_waddr_r;
    c_din_nxt_s    = c_din_r;
    c_rlen_nxt_s   = c_rlen_r;
    c_wlen_nxt_s   = c_wlen_r;
    p0_rack_nxt_s  = 1'b0;
    p1_rack_nxt_s  = 1'b0;
    p1_wack_nxt_s  = 1'b0;
    p0_dout_nxt_s  = p0_dout_r;
    p1_dout_nxt_s  = p1_dout_r;
    err_nxt_s      = err_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_s.valid) begin
          last_gnt_nxt_s = gnt_s.port;
          cur_wr_nxt_s   = gnt_s.wr;
          wd_nxt_s       = {WD_W{1'b0}};
          if (gnt_s.port == PORT_FETCH) begin
            c_re_nxt_s    = 1'b1;
            c_raddr_nxt_s = bus.p0_raddr;
            c_rlen_nxt_s  = bus.p0_rlen;
          end else if (gnt_s.wr) begin
            c_we_nxt_s    = 1'b1;
            c_waddr_nxt_s = bus.p1_waddr;
            c_din_nxt_s   = bus.p1_din;
            c_wlen_nxt_s  = bus.p1_wlen;
          end else begin
            c_re_nxt_s    = 1'b1;
            c_raddr_nxt_s = bus.p1_raddr;
            c_rlen_nxt_s  = bus.p1_rlen;
          end
        end else begin
          wd_nxt_s = wd_r;
        end
      end
      ST_WAIT: begin
        if (done_s) begin
          c_re_nxt_s = 1'b0;
          c_we_nxt_s = 1'b0;
          if (timeout_s) err_nxt_s = 1'b1; else err_nxt_s = err_r;
          if (cur_wr_r) begin
            p1_wack_nxt_s = 1'b1;
          end else if (last_gnt_r == PORT_FETCH) begin
            p0_rack_nxt_s = 1'b1;
            p0_dout_nxt_s = rdata_s;
          end else begin
            p1_rack_nxt_s = 1'b1;
            p1_dout_nxt_s = rdata_s;
          end
        end else begin
          wd_nxt_s = wd_r + WD_W'(1);
        end
      end
      ST_RELEASE: wd_nxt_s = wd_r;
      default:    wd_nxt_s = {WD_W{1'b0}};
    endcase
  end

  // Output and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_r <= PORT_LSU;
      cur_wr_r   <= 1'b0;
      wd_r       <= {WD_W{1'b0}};
      c_re_r     <= 1'b0;
      c_we_r     <= 1'b0;
      c_raddr_r  <= {MADDR_L{1'b0}};
      c_waddr_r  <= {MADDR_L{1'b0}};
      c_din_r    <= {C_DATA_L{1'b0}};
      c_rlen_r   <= {RW_LEN_L{1'b0}};
      c_wlen_r   <= {RW_LEN_L{1'b0}};
      p0_rack_r  <= 1'b0;
      p1_rack_r  <= 1'b0;
      p1_wack_r  <= 1'b0;
      p0_dout_r  <= {C_DATA_L{1'b0}};
      p1_dout_r  <= {C_DATA_L{1'b0}};
      err_r      <= 1'b0;
    end else begin
      last_gnt_r <= last_gnt_nxt_s;
      cur_wr_r   <= cur_wr_nxt_s;
      wd_r       <= wd_nxt_s;
      c_re_r     <= c_re_nxt_s;
      c_we_r     <= c_we_nxt_s;
      c_raddr_r  <= c_raddr_nxt_s;
      c_waddr_r  <= c_waddr_nxt_s;
      c_din_r    <= c_din_nxt_s;
      c_rlen_r   <= c_rlen_nxt_s;
      c_wlen_r   <= c_wlen_nxt_s;
      p0_rack_r  <= p0_rack_nxt_s;
      p1_rack_r  <= p1_rack_nxt_s;
      p1_wack_r  <= p1_wack_nxt_s;
      p0_dout_r  <= p0_dout_nxt_s;
      p1_dout_r  <= p1_dout_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  assign bus.c_re    = c_re_r;
  assign bus.c_we    = c_we_r;
  assign bus.c_raddr = c_raddr_r;
  assign bus.c_waddr = c_waddr_r;
  assign bus.c_din   = c_din_r;
  assign bus.c_rlen  = c_rlen_r;
  assign bus.c_wlen  = c_wlen_r;
  assign bus.p0_rack = p0_rack_r;
  assign bus.p1_rack = p1_rack_r;
  assign bus.p1_wack = p1_wack_r;
  assign bus.p0_dout = p0_dout_r;
  assign bus.p1_dout = p1_dout_r;
  assign err         = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both requesters and the
// controller cycle by cycle, driving and sampling on the falling clock edge.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_arbiter_if #(.DW(32), .AW(32)) bus ();

  mem_arbiter #(.C_DATA_L(32), .MADDR_L(32), .TO_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master),
    .err (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic quiet_inputs();
    bus.p0_re = 1'b0; bus.p0_raddr = 32'h0; bus.p0_rlen = 2'd0;
    bus.p1_re = 1'b0; bus.p1_we = 1'b0; bus.p1_raddr = 32'h0; bus.p1_waddr = 32'h0;
    bus.p1_din = 32'h0; bus.p1_rlen = 2'd0; bus.p1_wlen = 2'd0;
    bus.c_dout = 32'h0; bus.c_rack = 1'b0; bus.c_wack = 1'b0;
  endtask

  initial begin
    quiet_inputs();
    #1;
    chk("rst_c_re", bus.c_re, 1'b0);
    chk("rst_c_we", bus.c_we, 1'b0);
    chk("rst_acks", {bus.p0_rack, bus.p1_rack, bus.p1_wack}, 3'b000);
    chk("rst_dout", {bus.p0_dout, bus.p1_dout}, 64'h0);
    chk("rst_err", err, 1'b0);
    nxt(2);
    rst = 1'b1;
    nxt(1);

    // 1: fetch alone, controller acks 5 cycles after the strobe rises
    bus.p0_re = 1'b1; bus.p0_raddr = 32'h100; bus.p0_rlen = 2'd3;
    nxt(1);
    chk("t1_c_re", bus.c_re, 1'b1);
    chk("t1_c_raddr", bus.c_raddr, 32'h100);
    chk("t1_c_rlen", bus.c_rlen, 2'd3);
    nxt(4);
    chk("t1_held", {bus.c_re, bus.p0_rack}, 2'b10);
    bus.c_rack = 1'b1; bus.c_dout = 32'hDEADBEEF;
    nxt(1);
    chk("t1_ack", {bus.p0_rack, bus.c_re}, 2'b10);
    chk("t1_dout", bus.p0_dout, 32'hDEADBEEF);
    bus.p0_re = 1'b0; bus.c_rack = 1'b0; bus.c_dout = 32'h0;
    nxt(1);
    chk("t1_pulse", bus.p0_rack, 1'b0);
    chk("t1_hold", bus.p0_dout, 32'hDEADBEEF);

    // 2b: tie right after a port-0 grant goes to port 1
    bus.p0_re = 1'b1; bus.p0_raddr = 32'h104;
    bus.p1_re = 1'b1; bus.p1_raddr = 32'h204;
    nxt(1);
    chk("t2b_c_raddr", bus.c_raddr, 32'h204);
    bus.c_rack = 1'b1; bus.c_dout = 32'hCAFE0001;
    nxt(1);
    chk("t2b_acks", {bus.p0_rack, bus.p1_rack, bus.p1_wack}, 3'b010);
    chk("t2b_p1dout", bus.p1_dout, 32'hCAFE0001);
    bus.p1_re = 1'b0; bus.c_rack = 1'b0;
    nxt(1);
    chk("t2b_gap", bus.c_re, 1'b0);
    nxt(1);
    chk("t2b_p0_raddr", {bus.c_re, bus.c_raddr}, {1'b1, 32'h104});
    bus.c_rack = 1'b1; bus.c_dout = 32'h0BAD0002;
    nxt(1);
    chk("t2b_p0ack", {bus.p0_rack, bus.p1_rack}, 2'b10);
    chk("t2b_p0dout", bus.p0_dout, 32'h0BAD0002);
    chk("t2b_p1keep", bus.p1_dout, 32'hCAFE0001);
    bus.p0_re = 1'b0; bus.c_rack = 1'b0;
    nxt(1);

    // 2: after reset, fetch and store together -> fetch first, then store
    rst = 1'b0;
    nxt(1);
    rst = 1'b1;
    chk("t2_rst_dout", bus.p0_dout, 32'h0);
    bus.p0_re = 1'b1; bus.p0_raddr = 32'h200;
    bus.p1_we = 1'b1; bus.p1_waddr = 32'h300; bus.p1_din = 32'h1234; bus.p1_wlen = 2'd2;
    nxt(1);
    chk("t2_first", {bus.c_re, bus.c_we}, 2'b10);
    chk("t2_c_raddr", bus.c_raddr, 32'h200);
    bus.c_rack = 1'b1; bus.c_dout = 32'hA5A5A5A5;
    nxt(1);
    chk("t2_p0ack", {bus.p0_rack, bus.p1_wack}, 2'b10);
    chk("t2_p0dout", bus.p0_dout, 32'hA5A5A5A5);
    bus.p0_re = 1'b0; bus.c_rack = 1'b0;
    nxt(1);
    chk("t2_gap", bus.c_we, 1'b0);
    nxt(1);
    chk("t2_c_we", {bus.c_we, bus.c_re}, 2'b10);
    chk("t2_wr_fields", {bus.c_waddr, bus.c_din}, {32'h300, 32'h1234});
    chk("t2_c_wlen", bus.c_wlen, 2'd2);
    bus.c_wack = 1'b1;
    nxt(1);
    chk("t2_wack", {bus.p1_wack, bus.p0_rack, bus.c_we}, 3'b100);
    bus.p1_we = 1'b0; bus.c_wack = 1'b0;
    nxt(1);

    // 3: port 1 load and store together -> store first, load later
    bus.p1_re = 1'b1; bus.p1_raddr = 32'h40; bus.p1_rlen = 2'd1;
    bus.p1_we = 1'b1; bus.p1_waddr = 32'h20; bus.p1_din = 32'h55; bus.p1_wlen = 2'd0;
    nxt(1);
    chk("t3_strobes", {bus.c_we, bus.c_re}, 2'b10);
    chk("t3_wr_fields", {bus.c_waddr, bus.c_din}, {32'h20, 32'h55});
    bus.c_wack = 1'b1;
    nxt(1);
    chk("t3_wack", {bus.p1_wack, bus.p1_rack}, 2'b10);
    bus.p1_we = 1'b0; bus.c_wack = 1'b0;
    nxt(1);
    chk("t3_gap", {bus.c_re, bus.p1_wack}, 2'b00);
    nxt(1);
    chk("t3_rd", {bus.c_re, bus.c_raddr}, {1'b1, 32'h40});
    chk("t3_c_rlen", bus.c_rlen, 2'd1);
    bus.c_rack = 1'b1; bus.c_dout = 32'h77;
    nxt(1);
    chk("t3_rack", {bus.p1_rack, bus.p1_wack}, 2'b10);
    chk("t3_p1dout", bus.p1_dout, 32'h77);
    bus.p1_re = 1'b0; bus.c_rack = 1'b0;
    nxt(1);

    // 4: no matching ack -> watchdog fires 16 cycles after the strobe rises
    bus.p0_re = 1'b1; bus.p0_raddr = 32'h500; bus.c_dout = 32'hFFFFFFFF;
    nxt(1);
    chk("t4_rise", bus.c_re, 1'b1);
    bus.c_wack = 1'b1;
    nxt(3);
    chk("t4_wrong_ack", {bus.c_re, bus.p0_rack}, 2'b10);
    bus.c_wack = 1'b0;
    nxt(12);
    chk("t4_last_wait", {bus.c_re, err}, 2'b10);
    nxt(1);
    chk("t4_timeout", {bus.c_re, err, bus.p0_rack}, 3'b011);
    chk("t4_dout_zero", bus.p0_dout, 32'h0);
    bus.p0_re = 1'b0; bus.c_dout = 32'h0;
    nxt(1);
    chk("t4_sticky", {bus.p0_rack, err}, 2'b01);

    // 5: controller holds c_rack after the ack -> no new grant until it drops
    bus.p1_re = 1'b1; bus.p1_raddr = 32'h80;
    nxt(1);
    chk("t5_rise", bus.c_re, 1'b1);
    bus.c_rack = 1'b1; bus.c_dout = 32'h1111;
    nxt(1);
    chk("t5_ack", {bus.p1_rack, bus.c_re}, 2'b10);
    chk("t5_p1dout", bus.p1_dout, 32'h1111);
    bus.p1_re = 1'b0; bus.p0_re = 1'b1; bus.p0_raddr = 32'h600;
    nxt(1);
    chk("t5_pulse", {bus.p1_rack, bus.c_re}, 2'b00);
    nxt(1);
    chk("t5_blocked", bus.c_re, 1'b0);
    bus.c_rack = 1'b0;
    nxt(1);
    chk("t5_idle", {bus.c_re, bus.p0_rack}, 2'b00);
    nxt(1);
    chk("t5_regrant", {bus.c_re, bus.c_raddr}, {1'b1, 32'h600});
    bus.c_rack = 1'b1; bus.c_dout = 32'h2222;
    nxt(1);
    chk("t5_p0ack", {bus.p0_rack, bus.p0_dout}, {1'b1, 32'h2222});
    chk("t5_err_sticky", err, 1'b1);
    bus.p0_re = 1'b0; bus.c_rack = 1'b0;
    nxt(1);

    // 6: reset during WAIT abandons the transaction
    bus.p0_re = 1'b1; bus.p0_raddr = 32'h700;
    nxt(1);
    chk("t6_rise", bus.c_re, 1'b1);
    #2;
    rst = 1'b0;
    bus.p0_re = 1'b0; bus.c_rack = 1'b1; bus.c_dout = 32'h3333;
    #1;
    chk("t6_async", {bus.c_re, err, bus.c_raddr}, {1'b0, 1'b0, 32'h0});
    chk("t6_dout", bus.p0_dout, 32'h0);
    nxt(1);
    rst = 1'b1; bus.c_rack = 1'b0; bus.c_dout = 32'h0;
    for (int i = 0; i < 3; i++) begin
      nxt(1);
      chk("t6_no_ack", {bus.p0_rack, bus.c_re}, 2'b00);
    end
    bus.p1_we = 1'b1; bus.p1_waddr = 32'h44; bus.p1_din = 32'h99;
    nxt(1);
    chk("t6_wr", {bus.c_we, bus.c_waddr, bus.c_din}, {1'b1, 32'h44, 32'h99});
    bus.c_wack = 1'b1;
    nxt(1);
    chk("t6_wack", {bus.p1_wack, bus.c_we}, 2'b10);
    bus.p1_we = 1'b0; bus.c_wack = 1'b0;
    nxt(1);
    chk("t6_wack_pulse", bus.p1_wack, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
